// File: rtl/alu_uart_sequencer.sv
// UART-to-ALU front end: assembles multi-byte operands and an opcode from the
// rx byte stream, commits them atomically to the ALU input registers, then
// serialises the ALU result MSB byte first through the tx core.
module alu_uart_sequencer #(
  parameter int unsigned WIDTH_WORD             = 8,
  parameter int unsigned CANT_DATOS_ENTRADA_ALU = 16,
  parameter int unsigned CANT_BITS_OPCODE_ALU   = 6,
  parameter int unsigned CANT_DATOS_SALIDA_ALU  = 16,
  parameter int unsigned TIMEOUT_CYCLES         = 50000
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [WIDTH_WORD-1:0]             i_data_rx,
  input  logic                              i_rx_done,
  input  logic                              i_tx_done,
  input  logic [CANT_DATOS_SALIDA_ALU-1:0]  i_resultado_alu,
  output logic                              o_tx_start,
  output logic [WIDTH_WORD-1:0]             o_data_tx,
  output logic [CANT_DATOS_ENTRADA_ALU-1:0] o_reg_dato_A,
  output logic [CANT_DATOS_ENTRADA_ALU-1:0] o_reg_dato_B,
  output logic [CANT_BITS_OPCODE_ALU-1:0]   o_reg_opcode,
  output logic                              o_valid,
  output logic                              o_error
);

  localparam int unsigned NA  = (CANT_DATOS_ENTRADA_ALU + WIDTH_WORD - 1) / WIDTH_WORD;
  localparam int unsigned NR  = (CANT_DATOS_SALIDA_ALU + WIDTH_WORD - 1) / WIDTH_WORD;
  localparam int unsigned SHW = NA * WIDTH_WORD;
  localparam int unsigned TXW = NR * WIDTH_WORD;

  localparam logic [2:0]  NaLast    = 3'(NA - 1);
  localparam logic [2:0]  NrLast    = 3'(NR - 1);
  localparam logic [31:0] ToLast    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic        TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    StRxA,
    StRxB,
    StRxOp,
    StLatch,
    StTxSend,
    StTxWait
  } state_e;

  state_e                            state_q, state_d;
  logic [2:0]                        byte_cnt_q, byte_cnt_d;
  logic [31:0]                       to_cnt_q, to_cnt_d;
  logic [SHW-1:0]                    shadow_a_q, shadow_a_d;
  logic [SHW-1:0]                    shadow_b_q, shadow_b_d;
  logic [TXW-1:0]                    tx_shift_q, tx_shift_d;
  logic [2:0]                        tx_left_q, tx_left_d;
  logic [WIDTH_WORD-1:0]             data_tx_q, data_tx_d;
  logic [CANT_DATOS_ENTRADA_ALU-1:0] reg_a_q, reg_a_d;
  logic [CANT_DATOS_ENTRADA_ALU-1:0] reg_b_q, reg_b_d;
  logic [CANT_BITS_OPCODE_ALU-1:0]   reg_op_q, reg_op_d;
  logic                              valid_q, valid_d;
  logic                              error_q, error_d;

  logic                              frame_started;
  logic                              timeout_hit;
  logic [TXW-1:0]                    res_ext;
  logic [TXW-1:0]                    tx_next;

  // State and datapath registers, synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StRxA;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      tx_shift_q <= '0;
      tx_left_q  <= '0;
      data_tx_q  <= '0;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      reg_op_q   <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      tx_shift_q <= tx_shift_d;
      tx_left_q  <= tx_left_d;
      data_tx_q  <= data_tx_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      reg_op_q   <= reg_op_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: frame parsing, commit, result serialisation, timeout
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    tx_shift_d = tx_shift_q;
    tx_left_d  = tx_left_q;
    data_tx_d  = data_tx_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    reg_op_d   = reg_op_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    res_ext = '0;
    res_ext[CANT_DATOS_SALIDA_ALU-1:0] = i_resultado_alu;
    tx_next = tx_shift_q << WIDTH_WORD;

    // The timeout only arms once the current frame has at least one byte
    frame_started = ((state_q == StRxA) && (byte_cnt_q != 3'd0)) ||
                    (state_q == StRxB) || (state_q == StRxOp);
    // A byte arriving in the expiry cycle wins over the timeout
    timeout_hit   = TimeoutEn && frame_started && !i_rx_done && (to_cnt_q == ToLast);
    to_cnt_d      = (frame_started && !i_rx_done) ? to_cnt_q + 32'd1 : 32'd0;

    case (state_q)
      StRxA: begin
        if (i_rx_done) begin
          shadow_a_d = SHW'({shadow_a_q, i_data_rx});
          if (byte_cnt_q == NaLast) begin
            byte_cnt_d = 3'd0;
            state_d    = StRxB;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      StRxB: begin
        if (i_rx_done) begin
          shadow_b_d = SHW'({shadow_b_q, i_data_rx});
          if (byte_cnt_q == NaLast) begin
            byte_cnt_d = 3'd0;
            state_d    = StRxOp;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      StRxOp: begin
        if (i_rx_done) begin
          // Atomic commit; bits above the operand width are dropped here
          reg_a_d    = shadow_a_q[CANT_DATOS_ENTRADA_ALU-1:0];
          reg_b_d    = shadow_b_q[CANT_DATOS_ENTRADA_ALU-1:0];
          reg_op_d   = i_data_rx[CANT_BITS_OPCODE_ALU-1:0];
          valid_d    = 1'b1;
          shadow_a_d = '0;
          shadow_b_d = '0;
          state_d    = StLatch;
        end
      end
      StLatch: begin
        // ALU inputs settled for one cycle; capture result and stage MSB byte
        tx_shift_d = res_ext;
        data_tx_d  = res_ext[TXW-1 -: WIDTH_WORD];
        tx_left_d  = NrLast;
        state_d    = StTxSend;
      end
      StTxSend: begin
        state_d = StTxWait;
      end
      StTxWait: begin
        if (i_tx_done) begin
          if (tx_left_q != 3'd0) begin
            tx_shift_d = tx_next;
            data_tx_d  = tx_next[TXW-1 -: WIDTH_WORD];
            tx_left_d  = tx_left_q - 3'd1;
            state_d    = StTxSend;
          end else begin
            state_d = StRxA;
          end
        end
      end
      default: begin
        state_d = StRxA;
      end
    endcase

    if (timeout_hit) begin
      error_d    = 1'b1;
      state_d    = StRxA;
      byte_cnt_d = 3'd0;
      shadow_a_d = '0;
      shadow_b_d = '0;
      to_cnt_d   = 32'd0;
    end
  end

  assign o_tx_start   = (state_q == StTxSend);
  assign o_data_tx    = data_tx_q;
  assign o_reg_dato_A = reg_a_q;
  assign o_reg_dato_B = reg_b_q;
  assign o_reg_opcode = reg_op_q;
  assign o_valid      = valid_q;
  assign o_error      = error_q;

endmodule
